// File: rtl/onehot_dec_pkg.sv
// Shared constants and the one-hot helper for the registered one-hot decoder.
// The helper returns a wide vector; callers keep the low NUM_OUT bits.
package onehot_dec_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_WALK   = 1'b1;

    // Upper bound on NUM_OUT supported by onehot_of
    localparam int MAX_OUT = 64;

    function automatic logic [MAX_OUT-1:0] onehot_of(input int idx, input int num_out);
        logic [MAX_OUT-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            v[i] = (i == idx) && (i < num_out);
        end
        return v;
    endfunction

endpackage

// File: rtl/dec_walk_ptr.sv
// Round-robin pointer for WALK mode: wraps at NUM_OUT, clear takes effect
// before the increment so a clear+inc beat uses index 0 and leaves the pointer at 1.
module dec_walk_ptr #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] idx_o
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OUT - 1);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] base;

    assign base  = clr_i ? '0 : ptr_q;
    assign idx_o = base;

    always_comb begin
        ptr_d = base;
        if (inc_i) begin
            ptr_d = (base == LAST) ? '0 : base + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/onehot_dec_reg.sv
// Registered binary-to-one-hot decoder with valid/ready handshake, a DIRECT
// range check that flags selects >= NUM_OUT, and a round-robin WALK mode.
module onehot_dec_reg
    import onehot_dec_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               walk_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic [SEL_W-1:0]   out_idx,
    output logic               out_err
);

    logic               out_valid_q,  out_valid_d;
    logic [NUM_OUT-1:0] out_onehot_q, out_onehot_d;
    logic [SEL_W-1:0]   out_idx_q,    out_idx_d;
    logic               out_err_q,    out_err_d;

    logic               accept;
    logic               walk_acc;
    logic               sel_oor;
    logic [SEL_W-1:0]   walk_idx;
    logic [MAX_OUT-1:0] dec_full;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign walk_acc = accept & (mode == MODE_WALK);
    assign sel_oor  = int'(sel) >= NUM_OUT;

    dec_walk_ptr #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_walk_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (walk_acc),
        .clr_i (walk_clr),
        .idx_o (walk_idx)
    );

    // Register only changes on accept or on a drain, so a stalled beat holds exactly
    always_comb begin
        out_valid_d  = out_valid_q;
        out_onehot_d = out_onehot_q;
        out_idx_d    = out_idx_q;
        out_err_d    = out_err_q;
        dec_full     = '0;
        if (accept) begin
            out_valid_d = 1'b1;
            if (mode == MODE_WALK) begin
                dec_full  = onehot_of(int'(walk_idx), NUM_OUT);
                out_idx_d = walk_idx;
                out_err_d = 1'b0;
            end else begin
                dec_full  = sel_oor ? '0 : onehot_of(int'(sel), NUM_OUT);
                out_idx_d = sel;
                out_err_d = sel_oor;
            end
            out_onehot_d = dec_full[NUM_OUT-1:0];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            out_idx_q    <= '0;
            out_err_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_idx_q    <= out_idx_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_idx    = out_idx_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_onehot_dec_reg.sv
// Scoreboard bench for onehot_dec_reg (SEL_W=3, NUM_OUT=5): driver pushes expected
// beats from an arithmetic model, a negedge monitor pops and compares on consume.
module tb_onehot_dec_reg;

    localparam int SEL_W   = 3;
    localparam int NUM_OUT = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [SEL_W-1:0]   sel = '0;
    logic               mode = 1'b0;
    logic               walk_clr = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [NUM_OUT-1:0] out_onehot;
    logic [SEL_W-1:0]   out_idx;
    logic               out_err;

    always #5 clk = ~clk;

    onehot_dec_reg #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .mode       (mode),
        .walk_clr   (walk_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .out_err    (out_err)
    );

    typedef struct {
        int idx;
        int onehot;
        bit err;
    } beat_t;

    beat_t q[$];
    beat_t pend;
    bit    pend_ok      = 1'b0;
    bit    rst_seen     = 1'b1;
    bit    zero_exp     = 1'b0;
    bit    exp_in_ready = 1'b1;
    int    ptr          = 0;
    int    total        = 0;
    int    bad          = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; also commits what the previous edge did to the model
    task automatic cycle(input bit r, input bit v, input int s, input bit m,
                         input bit c, input bit rdy);
        @(posedge clk);
        #2;
        if (rst_seen) begin
            q.delete();
            ptr      = 0;
            zero_exp = 1'b1;
        end else if (pend_ok) begin
            q.push_back(pend);
            zero_exp = 1'b0;
        end
        pend_ok   = 1'b0;
        rst       = r;
        in_valid  = v;
        sel       = SEL_W'(s);
        mode      = m;
        walk_clr  = c;
        out_ready = rdy;
        exp_in_ready = (q.size() == 0) || rdy;
        rst_seen  = r;
        if (!r) begin
            if (c) ptr = 0;
            if (v && exp_in_ready) begin
                pend_ok = 1'b1;
                if (m) begin
                    pend.idx    = ptr;
                    pend.err    = 1'b0;
                    pend.onehot = 1 << ptr;
                    ptr         = (ptr + 1) % NUM_OUT;
                end else begin
                    pend.idx    = s;
                    pend.err    = (s >= NUM_OUT);
                    pend.onehot = pend.err ? 0 : (1 << s);
                end
                $display("beat: mode=%0d sel=%0d clr=%0d -> idx=%0d onehot=%05b err=%0d",
                         m, s, c, pend.idx, pend.onehot, pend.err);
            end
        end
    endtask

    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(exp_in_ready));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_onehot", 32'(out_onehot), 32'(q[0].onehot));
            check("out_idx", 32'(out_idx), 32'(q[0].idx));
            check("out_err", 32'(out_err), 32'(q[0].err));
            if (out_ready && !rst) void'(q.pop_front());
        end else if (zero_exp) begin
            check("reset_onehot", 32'(out_onehot), 32'd0);
            check("reset_idx", 32'(out_idx), 32'd0);
            check("reset_err", 32'(out_err), 32'd0);
        end
    end

    initial begin
        repeat (2) cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        // back-to-back DIRECT, every legal select
        for (int i = 0; i < NUM_OUT; i++) cycle(0, 1, i, 0, 0, 1);
        // out-of-range selects
        cycle(0, 1, 6, 0, 0, 1);
        cycle(0, 1, 5, 0, 0, 1);
        cycle(0, 1, 7, 0, 0, 1);
        // WALK, 7 accepts: wraps at NUM_OUT, pointer ends at 2
        for (int i = 0; i < 7; i++) cycle(0, 1, 7, 1, 0, 1);
        // stall with a waiting beat, then release
        cycle(0, 1, 2, 0, 0, 1);
        repeat (4) cycle(0, 1, 3, 0, 0, 0);
        cycle(0, 1, 3, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // clear with a WALK accept (ptr was 2), then a plain WALK beat
        cycle(0, 1, 0, 1, 1, 1);
        cycle(0, 1, 0, 1, 0, 1);
        cycle(0, 1, 0, 1, 0, 1);
        // clear without accept, clear with DIRECT accept
        cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 1, 0, 1, 0, 1);
        cycle(0, 1, 4, 0, 1, 1);
        cycle(0, 1, 0, 1, 0, 1);
        // reset while FULL and stalled, then a WALK beat must restart at 0
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 1, 2, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 1, 0, 1);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check("drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
